add_share_sched: RTL and testbench

Round-robin scheduler that shares one single-cycle-latency adder (start/a/b in, y/valid out one cycle later) between N requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and issues a one-cycle start pulse to the adder. It captures the adder result and returns it with the winning requester's ID over a valid/ready response channel. It sits between the client ports and the adder instance; only this block drives the adder.

---
 rtl/add_share_sched_pkg.sv | 29 ++
 rtl/add_share_sched_if.sv | 31 +++
 rtl/add_share_sched_rr_pick.sv | 36 +++
 rtl/add_share_sched.sv | 126 ++++++++++++
 tb/tb_add_share_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_sched_pkg.sv
// Shared types and sizing helpers for the adder-sharing scheduler and its
// round-robin picker.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 4;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The wait counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout + 1) : 1;
  endfunction

  localparam int IDW_DEF = id_width(N_DEF);
  localparam int CW_DEF  = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/add_share_sched_if.sv
// Client-side bundle: per-requester operand handshakes plus the shared
// response channel.
interface add_share_sched_if #(
  parameter int N = 4,
  parameter int W = 16
);
  import add_share_pkg::*;

  localparam int IDW = id_width(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;
  logic           rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
  );

endinterface

// File: rtl/add_share_sched_rr_pick.sv
// Combinational round-robin picker: the first set request searching upward
// from ptr_i+1, wrapping at N-1, wins.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o
);

  int             j;
  logic [IDW-1:0] jj;

  // NOTE: every output of a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    jj      = '0;
    // Walk from lowest to highest priority so the highest-priority hit
    // is the last one written.
    for (int k = N; k >= 1; k--) begin
      j  = (int'(ptr_i) + k) % N;
      jj = IDW'(j);
      if (req_i[jj]) begin
        grant_o     = '0;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
      end
    end
  end

endmodule

// File: rtl/add_share_sched.sv
// Shares one single-cycle adder between N requesters: round-robin accept,
// one start pulse, bounded wait for the result, registered response.
module add_share_sched
  import add_share_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  add_share_sched_if.slave bus,
  output logic             add_start,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_y,
  input  logic             add_valid
);

  localparam int IDW = id_width(N);
  localparam int CW  = cnt_width(TIMEOUT);

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           add_start_q;
  logic [W-1:0]   add_a_q;
  logic [W-1:0]   add_b_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_y_q;
  logic           rsp_err_q;

  logic [N-1:0]   pick_grant;
  logic [IDW-1:0] pick_idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .req_i  (bus.req_valid),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx)
  );

  assign a_sel = bus.req_a[int'(pick_idx)*W +: W];
  assign b_sel = bus.req_b[int'(pick_idx)*W +: W];
  assign cnt_d = cnt_q + 1'b1;

  // The grant is only exposed while idle, so at most one accept is in flight.
  assign bus.req_ready = (state_q == IDLE) ? pick_grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_err   = rsp_err_q;
  assign add_start     = add_start_q;
  assign add_a         = add_a_q;
  assign add_b         = add_b_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|pick_grant) begin
            add_a_q     <= a_sel;
            add_b_q     <= b_sel;
            id_q        <= pick_idx;
            add_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (add_valid) begin
            rsp_y_q     <= add_y;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CW'(TIMEOUT)) begin
              rsp_y_q     <= '0;
              rsp_err_q   <= 1'b1;
              rsp_id_q    <= id_q;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= rsp_id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched with a behavioural single-cycle adder
// that can be silenced or made to fire spuriously.
module tb_add_share_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          add_start;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W-1:0]  add_y;
  logic          add_valid;

  logic          adder_en;
  logic          late_valid;
  logic          stub_valid;
  logic [W-1:0]  stub_y;

  int checks = 0;
  int errors = 0;

  add_share_sched_if #(.N(N), .W(W)) bus ();

  add_share_sched #(.N(N), .W(W), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_start(add_start),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_y    (add_y),
    .add_valid(add_valid)
  );

  always @(posedge clk) begin
    stub_valid <= add_start & adder_en;
    stub_y     <= add_a + add_b;
  end
  assign add_valid = stub_valid | late_valid;
  assign add_y     = stub_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, steps to ISSUE, then waits for the response and
  // checks grant, start pulse, latency from ISSUE and response fields.
  task automatic serve(input string tag, input int exp_id, input logic [15:0] exp_y,
                       input logic exp_err, input int exp_lat, input bit drop,
                       output int gap);
    int lat;
    gap = 0;
    #1;
    while (bus.req_ready === '0 && gap < 20) begin
      @(negedge clk);
      #1;
      gap++;
    end
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << exp_id));
    @(negedge clk);
    if (drop) bus.req_valid[exp_id] = 1'b0;
    check({tag, "_start"}, 32'(add_start), 32'd1);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check({tag, "_id"},    32'(bus.rsp_id), 32'(exp_id));
    check({tag, "_y"},     32'(bus.rsp_y), 32'(exp_y));
    check({tag, "_err"},   32'(bus.rsp_err), 32'(exp_err));
  endtask

  task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
  endtask

  int               gap;
  logic [15:0]      fair_y [4];
  int               fair_order [5];

  initial begin
    fair_y     = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    fair_order = '{0, 1, 2, 3, 0};
    rst           = 1'b1;
    adder_en      = 1'b1;
    late_valid    = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_y",     32'(bus.rsp_y),     32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_add_start", 32'(add_start),     32'd0);
    check("rst_add_a",     32'(add_a),         32'd0);
    check("rst_add_b",     32'(add_b),         32'd0);
    rst = 1'b0;

    // Single request from requester 2, step by step
    @(negedge clk);
    set_ops(2, 16'h0123, 16'h0456);
    bus.req_valid = 4'b0100;
    #1;
    check("single_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    check("single_start_t1", 32'(add_start), 32'd1);
    check("single_add_a",    32'(add_a), 32'h0123);
    check("single_add_b",    32'(add_b), 32'h0456);
    check("single_ready_t1", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("single_start_t2", 32'(add_start), 32'd0);
    check("single_valid_t2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("single_valid_t3", 32'(bus.rsp_valid), 32'd1);
    check("single_id",       32'(bus.rsp_id), 32'd2);
    check("single_y",        32'(bus.rsp_y), 32'h0579);
    check("single_err",      32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("single_done", 32'(bus.rsp_valid), 32'd0);

    // Fairness: all requesters valid continuously from reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 16'(16'h1000 * (i + 1)), 16'(i + 1));
    bus.req_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      serve($sformatf("fair%0d", t), fair_order[t], fair_y[fair_order[t]], 1'b0, 2, 1'b0, gap);
      if (t > 0) check($sformatf("fair%0d_gap", t), 32'(gap), 32'd1);
    end
    bus.req_valid = '0;

    // Wrap-around sum from requester 1
    set_ops(1, 16'hFFFF, 16'h0002);
    bus.req_valid = 4'b0010;
    serve("wrap", 1, 16'h0001, 1'b0, 2, 1'b1, gap);
    @(negedge clk);

    // Backpressure: response held five cycles, requester 0 kept waiting
    bus.rsp_ready = 1'b0;
    set_ops(0, 16'h0001, 16'h0001);
    set_ops(3, 16'h00AA, 16'h0055);
    bus.req_valid = 4'b1001;
    serve("bp", 3, 16'h00FF, 1'b0, 2, 1'b1, gap);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d_id", c),    32'(bus.rsp_id), 32'd3);
      check($sformatf("bp_hold%0d_y", c),     32'(bus.rsp_y), 32'h00FF);
      check($sformatf("bp_hold%0d_ready", c), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_released", 32'(bus.rsp_valid), 32'd0);
    check("bp_next_grant", 32'(bus.req_ready), 32'h1);
    serve("bp_next", 0, 16'h0002, 1'b0, 2, 1'b1, gap);
    @(negedge clk);

    // Timeout: adder silent, error response at T+6, late valid ignored
    adder_en = 1'b0;
    set_ops(2, 16'h1111, 16'h2222);
    bus.req_valid = 4'b0100;
    serve("tmo", 2, 16'h0000, 1'b1, 5, 1'b1, gap);
    @(negedge clk);
    check("tmo_done", 32'(bus.rsp_valid), 32'd0);
    late_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("tmo_late%0d", c), 32'(bus.rsp_valid), 32'd0);
    end
    late_valid = 1'b0;
    @(negedge clk);
    check("tmo_after_late_valid", 32'(bus.rsp_valid), 32'd0);
    check("tmo_after_late_start", 32'(add_start), 32'd0);

    // Reset during WAIT drops the transaction and restores priority to 0
    set_ops(1, 16'h0003, 16'h0004);
    bus.req_valid = 4'b0010;
    #1;
    check("rstw_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstw_add_start", 32'(add_start), 32'd0);
    check("rstw_add_a",     32'(add_a), 32'd0);
    check("rstw_add_b",     32'(add_b), 32'd0);
    check("rstw_rsp_id",    32'(bus.rsp_id), 32'd0);
    check("rstw_rsp_y",     32'(bus.rsp_y), 32'd0);
    check("rstw_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rstw_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    adder_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstw_quiet%0d", c), 32'(bus.rsp_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) set_ops(i, 16'(16'h1000 * (i + 1)), 16'(i + 1));
    bus.req_valid = 4'hF;
    serve("post_rst", 0, 16'h1001, 1'b0, 2, 1'b0, gap);
    bus.req_valid = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
